// File: rtl/axil_regfile_bridge.sv
// axil_regfile_bridge: AXI4-Lite slave serialising register accesses onto a single-port BRAM-style strobe bus.
// Optional range checking (SLVERR, suppressed strobe) is compiled in with AXIL_BRIDGE_RANGE_CHECK_EN.
module axil_regfile_bridge #(
    parameter int Naddr = 4,
    parameter int Abits = 16,
    parameter int Nregs = 2 ** Naddr
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Abits-1:0] s_axi_awaddr,
    input  logic             s_axi_awvalid,
    output logic             s_axi_awready,
    input  logic [31:0]      s_axi_wdata,
    input  logic [3:0]       s_axi_wstrb,
    input  logic             s_axi_wvalid,
    output logic             s_axi_wready,
    output logic [1:0]       s_axi_bresp,
    output logic             s_axi_bvalid,
    input  logic             s_axi_bready,
    input  logic [Abits-1:0] s_axi_araddr,
    input  logic             s_axi_arvalid,
    output logic             s_axi_arready,
    output logic [31:0]      s_axi_rdata,
    output logic [1:0]       s_axi_rresp,
    output logic             s_axi_rvalid,
    input  logic             s_axi_rready,
    output logic [Naddr-1:0] addr,
    output logic [31:0]      wr_data,
    input  logic [31:0]      rd_data,
    output logic             en,
    output logic [3:0]       we
);
    typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP} state_t;
    state_t state_q;
    logic last_wr_q, err_q, en_q, bvalid_q, rvalid_q;
    logic [3:0] we_q;
    logic [1:0] bresp_q, rresp_q;
    logic [31:0] wr_data_q, rdata_q;
    logic [Naddr-1:0] addr_q;
    logic wr_grant, rd_grant, aw_err, ar_err, err_d, unused_ok;
    // A write needs AW and W together; on contention the type not served last wins.
    assign wr_grant = state_q == IDLE && s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !last_wr_q);
    assign rd_grant = state_q == IDLE && s_axi_arvalid && !wr_grant;
    assign err_d = wr_grant ? aw_err : ar_err;
`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
    assign aw_err = (s_axi_awaddr >> (Naddr + 2)) != '0 || 32'(s_axi_awaddr[Naddr+1:2]) >= 32'(Nregs);
    assign ar_err = (s_axi_araddr >> (Naddr + 2)) != '0 || 32'(s_axi_araddr[Naddr+1:2]) >= 32'(Nregs);
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
    assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, 32'(Nregs)};
`endif
    assign s_axi_awready = wr_grant;
    assign s_axi_wready  = wr_grant;
    assign s_axi_arready = rd_grant;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign addr          = addr_q;
    assign wr_data       = wr_data_q;
    assign en            = en_q;
    assign we            = we_q;
    // Transaction FSM: one access in flight, single-cycle strobe, registered responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_grant) begin
                        addr_q    <= s_axi_awaddr[Naddr+1:2];
                        wr_data_q <= s_axi_wdata;
                        en_q      <= !err_d;
                        we_q      <= err_d ? 4'h0 : s_axi_wstrb;
                        err_q     <= err_d;
                        last_wr_q <= 1'b1;
                        state_q   <= WR_EXEC;
                    end else if (rd_grant) begin
                        addr_q    <= s_axi_araddr[Naddr+1:2];
                        en_q      <= !err_d;
                        err_q     <= err_d;
                        last_wr_q <= 1'b0;
                        state_q   <= RD_EXEC;
                    end
                end
                WR_EXEC: begin
                    en_q     <= 1'b0;
                    we_q     <= '0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= err_q ? 2'b10 : 2'b00;
                    state_q  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_EXEC: begin
                    en_q    <= 1'b0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    rdata_q  <= err_q ? 32'h0 : rd_data;
                    rresp_q  <= err_q ? 2'b10 : 2'b00;
                    rvalid_q <= 1'b1;
                    state_q  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_regfile_bridge.sv
// tb_axil_regfile_bridge: randomized self-checking bench for axil_regfile_bridge against a word-array reference model.
module tb_axil_regfile_bridge;
    localparam int NADDR = 4;
    localparam int ABITS = 16;
`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
    localparam int NREGS = 10;
    localparam bit RANGE_EN = 1'b1;
`else
    localparam int NREGS = 16;
    localparam bit RANGE_EN = 1'b0;
`endif
    logic clk = 1'b0, resetn = 1'b0;
    logic [ABITS-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, en;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata, wr_data;
    logic [31:0] rd_data = '0;
    logic [NADDR-1:0] addr;
    logic [3:0] we;
    logic preload = 1'b1;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic en_prev = 1'b0;
    int vec = 0, errs = 0;

    axil_regfile_bridge #(.Naddr(NADDR), .Abits(ABITS), .Nregs(NREGS)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .en(en), .we(we)
    );

    always #5 clk = ~clk;

    // Downstream register file: byte-strobed writes, one-cycle registered read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (en) begin
            for (int b = 0; b < 4; b++) if (we[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            rd_data <= mem[addr];
        end
    end

    // Strobe shape: en never on two consecutive cycles, we only alongside en.
    always @(negedge clk) begin
        vec++;
        if ((en && en_prev) || (we != 4'h0 && !en)) begin
            errs++;
            $display("FAIL strobe_shape en=%b prev_en=%b we=%h required single-cycle en and we=0 without en", en, en_prev, we);
        end
        en_prev = en;
    end

    logic exp_last_wr = 1'b0;

    function automatic logic is_err(input logic [15:0] a);
        return (RANGE_EN && (a >> (NADDR + 2)) != 16'h0) || int'(a[5:2]) >= NREGS;
    endfunction

    function automatic logic [15:0] gen_addr();
        logic [3:0] i = 4'($urandom_range(0, NREGS - 1));
        logic [1:0] lo = 2'($urandom_range(0, 3));
        return RANGE_EN ? {10'h0, i, lo} : 16'($urandom);
    endfunction

    task automatic wr_finish(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s, input logic err, input int stall);
        logic [1:0] exp_resp = err ? 2'b10 : 2'b00;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        vec++;
        if (en !== !err || we !== (err ? 4'h0 : s) || (!err && (addr !== idx || wr_data !== d))) begin
            errs++;
            $display("FAIL wr_exec en=%b we=%h addr=%0d wr_data=%h required en=%b we=%h addr=%0d wr_data=%h",
                     en, we, addr, wr_data, !err, err ? 4'h0 : s, idx, d);
        end
        @(negedge clk);
        vec++;
        if (en !== 1'b0 || bvalid !== 1'b1 || bresp !== exp_resp) begin
            errs++;
            $display("FAIL wr_resp en=%b bvalid=%b bresp=%b required en=0 bvalid=1 bresp=%b", en, bvalid, bresp, exp_resp);
        end
        repeat (stall) begin
            arvalid = 1; araddr = gen_addr();
            @(negedge clk);
            vec++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || arready !== 1'b0) begin
                errs++;
                $display("FAIL wr_stall bvalid=%b bresp=%b arready=%b required bvalid=1 bresp=%b arready=0", bvalid, bresp, arready, exp_resp);
            end
        end
        arvalid = 0; bready = 1;
        @(negedge clk);
        bready = 0;
        vec++;
        if (bvalid !== 1'b0) begin
            errs++;
            $display("FAIL wr_done bvalid=%b required 0", bvalid);
        end
        if (!err) for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        exp_last_wr = 1'b1;
    endtask

    task automatic rd_finish(input logic [3:0] idx, input logic err, input int stall);
        logic [31:0] exp_d = err ? 32'h0 : ref_mem[idx];
        logic [1:0] exp_resp = err ? 2'b10 : 2'b00;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        vec++;
        if (en !== !err || we !== 4'h0 || (!err && addr !== idx)) begin
            errs++;
            $display("FAIL rd_exec en=%b we=%h addr=%0d required en=%b we=0 addr=%0d", en, we, addr, !err, idx);
        end
        @(negedge clk);
        vec++;
        if (en !== 1'b0 || rvalid !== 1'b0) begin
            errs++;
            $display("FAIL rd_wait en=%b rvalid=%b required en=0 rvalid=0", en, rvalid);
        end
        @(negedge clk);
        vec++;
        if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_resp) begin
            errs++;
            $display("FAIL rd_resp rvalid=%b rdata=%h rresp=%b required rvalid=1 rdata=%h rresp=%b", rvalid, rdata, rresp, exp_d, exp_resp);
        end
        repeat (stall) begin
            awvalid = 1; wvalid = 1; awaddr = gen_addr();
            @(negedge clk);
            vec++;
            if (rvalid !== 1'b1 || rdata !== exp_d || awready !== 1'b0) begin
                errs++;
                $display("FAIL rd_stall rvalid=%b rdata=%h awready=%b required rvalid=1 rdata=%h awready=0", rvalid, rdata, awready, exp_d);
            end
        end
        awvalid = 0; wvalid = 0; rready = 1;
        @(negedge clk);
        rready = 0;
        vec++;
        if (rvalid !== 1'b0) begin
            errs++;
            $display("FAIL rd_done rvalid=%b required 0", rvalid);
        end
        exp_last_wr = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        #1;
        vec++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b0) begin
            errs++;
            $display("FAIL wr_handshake awready=%b wready=%b arready=%b required 1 1 0", awready, wready, arready);
        end
        @(posedge clk);
        wr_finish(a[5:2], d, s, is_err(a), $urandom_range(0, 3));
    endtask

    task automatic do_read(input logic [15:0] a);
        @(negedge clk);
        araddr = a; arvalid = 1;
        #1;
        vec++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            errs++;
            $display("FAIL rd_handshake arready=%b awready=%b required 1 0", arready, awready);
        end
        @(posedge clk);
        rd_finish(a[5:2], is_err(a), $urandom_range(0, 3));
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if (en !== 0 || we !== 0 || addr !== 0 || wr_data !== 0 || rdata !== 0 || bresp !== 0 || rresp !== 0 ||
            bvalid !== 0 || rvalid !== 0 || awready !== 0 || wready !== 0 || arready !== 0) begin
            errs++;
            $display("FAIL reset_state en=%b we=%h addr=%0d wr_data=%h rdata=%h bresp=%b rresp=%b bv=%b rv=%b aw=%b w=%b ar=%b required all 0",
                     en, we, addr, wr_data, rdata, bresp, rresp, bvalid, rvalid, awready, wready, arready);
        end
        preload = 0;
        resetn = 1;
    endtask

    task automatic test_write();
        do_write(16'h0008, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_read_latency();
        do_read(16'h0014);
        do_read(16'h0008);
    endtask

    task automatic test_contention();
        @(negedge clk);
        #2 resetn = 0;
        @(negedge clk);
        resetn = 1;
        exp_last_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic exp_w = (i % 2 == 0);
            logic [15:0] wa = gen_addr(), ra = gen_addr();
            logic [31:0] d = $urandom;
            logic [3:0] s = 4'($urandom);
            @(negedge clk);
            awaddr = wa; araddr = ra; wdata = d; wstrb = s;
            awvalid = 1; wvalid = 1; arvalid = 1;
            #1;
            vec++;
            if (awready !== exp_w || wready !== exp_w || arready !== !exp_w) begin
                errs++;
                $display("FAIL contention_grant%0d awready=%b wready=%b arready=%b required %b %b %b", i, awready, wready, arready, exp_w, exp_w, !exp_w);
            end
            @(posedge clk);
            if (exp_w) wr_finish(wa[5:2], d, s, is_err(wa), 0);
            else rd_finish(ra[5:2], is_err(ra), 0);
        end
    endtask

    task automatic test_partial_write();
        logic [15:0] a = gen_addr();
        logic [31:0] d = $urandom;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = 4'h3; awvalid = 1; wvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec++;
            if (awready !== 1'b0 || wready !== 1'b0 || en !== 1'b0) begin
                errs++;
                $display("FAIL aw_alone cycle%0d awready=%b wready=%b en=%b required 0 0 0", i, awready, wready, en);
            end
        end
        wvalid = 1;
        #1;
        vec++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            errs++;
            $display("FAIL aw_w_join awready=%b wready=%b required 1 1", awready, wready);
        end
        @(posedge clk);
        wr_finish(a[5:2], d, 4'h3, is_err(a), 1);
        do_read(a);
    endtask

    task automatic test_zero_strobe();
        logic [15:0] a = gen_addr();
        do_write(a, $urandom, 4'h0);
        do_read(a);
    endtask

    task automatic test_backpressure_reset();
        logic [15:0] a = gen_addr();
        logic [31:0] exp_d = ref_mem[a[5:2]];
        @(negedge clk);
        araddr = a; arvalid = 1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            vec++;
            if (rvalid !== 1'b1 || rdata !== exp_d) begin
                errs++;
                $display("FAIL rd_backpressure cycle%0d rvalid=%b rdata=%h required 1 %h", i, rvalid, rdata, exp_d);
            end
            @(negedge clk);
        end
        #2 resetn = 0;
        #1;
        vec++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || en !== 1'b0 || rresp !== 2'b00 || arready !== 1'b0) begin
            errs++;
            $display("FAIL async_reset rvalid=%b rdata=%h en=%b rresp=%b arready=%b required all 0", rvalid, rdata, en, rresp, arready);
        end
        @(negedge clk);
        resetn = 1;
        exp_last_wr = 1'b0;
        do_read(a);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a = gen_addr();
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
            else do_read(a);
        end
    endtask

`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
    task automatic test_range_check();
        logic [31:0] keep = ref_mem[10];
        do_write(16'h0028, $urandom, 4'hF);
        do_read(16'h0028);
        do_write(16'h0404, $urandom, 4'hF);
        do_read(16'h0404);
        do_read(16'h0024);
        vec++;
        if (ref_mem[10] !== keep) begin
            errs++;
            $display("FAIL range_model ref10=%h required %h", ref_mem[10], keep);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'h12345678;
        repeat (2) @(posedge clk);
        test_reset();
        test_write();
        test_read_latency();
        test_contention();
        test_partial_write();
        test_zero_strobe();
        test_backpressure_reset();
        test_random();
`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
        test_range_check();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/axil_regfile_bridge.md
Name: axil_regfile_bridge

Overview:
- AXI4-Lite slave that converts PS register accesses into the single-port BRAM-style strobe interface consumed by mem_regfile (addr, wr_data, en, we, rd_data with 1-cycle read latency).
- Sits directly upstream of mem_regfile. Used where a register file is instantiated without an IPI AXI BRAM controller.
- Serialises accesses: one transaction in flight at a time, with fair read/write arbitration.

Parameters:
- Naddr, 4, register (word) address width driven on addr.
- Abits, 16, AXI byte-address width; must be >= Naddr+2.
- Nregs, 2**Naddr, number of implemented registers; used only by the optional range check.

Ports:
- clk  in  1  single clock for AXI and BRAM sides.
- resetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  Abits  write byte address.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write address handshake.
- s_axi_wdata  in  32 / s_axi_wstrb  in  4  write data and byte strobes.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write data handshake.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response.
- s_axi_araddr  in  Abits / s_axi_arvalid  in  1 / s_axi_arready  out  1  read address.
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read response.
- addr  out  Naddr  register index = byte address bits [Naddr+1:2].
- wr_data  out  32  write data to the register file.
- rd_data  in  32  register file read data, valid one cycle after en.
- en  out  1  access strobe, one cycle per transaction.
- we  out  4  byte write enables; 0 for reads.

Behaviour:
- Reset (resetn low, async):
  - state=IDLE.
  - All ready/valid outputs 0; en=0, we=0, addr=0, wr_data=0.
  - rdata=0, bresp=0, rresp=0.
  - Arbitration flag last_wr=0, so a write wins the first contention.
- States: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE:
  - A write candidate requires awvalid && wvalid together. AW or W alone is never accepted: awready and wready stay 0.
  - A read candidate requires arvalid.
  - If both candidates are present, grant the type opposite to last_wr. If only one is present, grant it.
  - awready, wready and arready are combinational from state, valids and grant, and are asserted only in IDLE.
- Write, handshake in cycle T:
  - T: register addr, wr_data, wstrb; last_wr<=1; go to WR_EXEC.
  - T+1: en=1, we=wstrb; go to WR_RESP.
  - T+2 onward: en=0, we=0, bvalid=1, bresp=OKAY(00).
  - bvalid is held until bready. On the bvalid&&bready cycle, go to IDLE. The next grant is possible on the following cycle.
- Read, handshake in cycle T:
  - T: register addr; last_wr<=0; go to RD_EXEC.
  - T+1: en=1, we=0; go to RD_WAIT.
  - T+2: rdata<=rd_data; go to RD_RESP.
  - T+3 onward: rvalid=1, rresp=OKAY. rdata is stable while rvalid && !rready. On the handshake, go to IDLE.
- Timing guarantees:
  - en is high for exactly one cycle per transaction and never high in any other state.
  - we is nonzero only when en is high.
  - wstrb=0 still produces en=1, we=0. This is a write with no effect and still returns a B response.
- Address: the low two address bits are ignored. Byte addresses beyond Naddr+2 bits wrap modulo 2**Naddr, except when the optional feature is enabled.
- Backpressure: bready/rready held low stalls the FSM indefinitely. No new handshake is accepted while stalled.
- Reset mid-transaction: all outputs return to their reset values immediately. The pending response is dropped and en is deasserted asynchronously.

Optional Feature:
- Macro: AXIL_BRIDGE_RANGE_CHECK_EN.
- Defined:
  - A transaction whose byte address has reg index >= Nregs, or any nonzero bit above Naddr+1, is still accepted through the normal handshake.
  - Its EXEC cycle asserts neither en nor we.
  - Response is SLVERR (10). Reads return rdata=0.
  - Latency is identical to a normal access.
- Undefined: no checking; upper bits are dropped (wrap) and responses are always OKAY.

Test Plan:
- Write reset value: write awaddr=0x0008, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: en=1, we=0xF, addr=2, wr_data=0xDEADBEEF exactly one cycle after the handshake.
  - Required: bvalid one cycle later with bresp=00.
- Read with latency: model rd_data = read_val[addr] with 1-cycle latency, read_val[5]=0x12345678; read araddr=0x0014.
  - Required: en=1, we=0, addr=5 at T+1.
  - Required: rvalid at T+3 with rdata=0x12345678, rresp=00.
- Contention and fairness: awvalid, wvalid and arvalid all asserted together, repeated 4 transactions.
  - Required grant order: W, R, W, R.
  - Required: never two en pulses closer than one transaction apart.
- Partial write / missing W: awvalid with wvalid held 0 for 10 cycles -> awready stays 0 and en stays 0. Then wvalid=1 with wstrb=0x3 -> we=0x3.
- Backpressure and reset: hold rready=0 for 20 cycles -> rvalid and rdata stable. Assert resetn=0 mid-wait -> rvalid=0 immediately and state=IDLE.
- Range check (with AXIL_BRIDGE_RANGE_CHECK_EN, Naddr=4, Nregs=10): write at byte address 0x0028 (index 10).
  - Required: en never asserted; bresp=10.
  - Required: a read of the same address returns rdata=0, rresp=10.
